// File: rtl/cam_capture_pkg.sv
// Shared types and constants for the camera capture controller.
package cam_capture_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        SYNC,
        CAPTURE,
        DONE
    } state_t;

    localparam int COL_W = 11;
    localparam int ROW_W = 10;
    localparam bit HI_BYTE_FIRST = 1'b1;

endpackage

// File: rtl/cam_input_sync.sv
// Two-flop synchronizers for the camera pins plus edge detection
// on pclk, vsync and href.
module cam_input_sync (
    input  logic       clk,
    input  logic       resetn,
    input  logic       cam_pclk,
    input  logic       cam_vsync,
    input  logic       cam_href,
    input  logic [7:0] cam_dat,
    output logic       pclk_rise,
    output logic       vs_rise,
    output logic       vs_fall,
    output logic       href_s2,
    output logic       href_fall,
    output logic [7:0] dat_s2
);

    // bit 0 = s1, bit 1 = s2, bit 2 = s3
    logic [2:0] pclk_q;
    logic [2:0] vs_q;
    logic [2:0] href_q;
    logic [7:0] dat_s1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pclk_q <= '0;
            vs_q   <= '0;
            href_q <= '0;
            dat_s1 <= '0;
            dat_s2 <= '0;
        end else begin
            pclk_q <= {pclk_q[1:0], cam_pclk};
            vs_q   <= {vs_q[1:0], cam_vsync};
            href_q <= {href_q[1:0], cam_href};
            dat_s1 <= cam_dat;
            dat_s2 <= dat_s1;
        end
    end

    assign pclk_rise = pclk_q[1] & ~pclk_q[2];
    assign vs_rise   = vs_q[1] & ~vs_q[2];
    assign vs_fall   = ~vs_q[1] & vs_q[2];
    assign href_s2   = href_q[1];
    assign href_fall = ~href_q[1] & href_q[2];

endmodule

// File: rtl/cam_capture_ctrl.sv
// Single-frame camera capture: waits for a frame boundary, crops a
// window, packs byte pairs into 16-bit pixels and writes them linearly.
module cam_capture_ctrl
    import cam_capture_pkg::*;
#(
    parameter int COLS   = 80,
    parameter int ROWS   = 60,
    parameter int X_OFF  = 0,
    parameter int Y_OFF  = 0,
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cam_pclk,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_dat,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);

    logic       pclk_rise;
    logic       vs_rise;
    logic       vs_fall;
    logic       href_s2;
    logic       href_fall;
    logic [7:0] dat_s2;

    cam_input_sync u_sync (
        .clk      (clk),
        .resetn   (resetn),
        .cam_pclk (cam_pclk),
        .cam_vsync(cam_vsync),
        .cam_href (cam_href),
        .cam_dat  (cam_dat),
        .pclk_rise(pclk_rise),
        .vs_rise  (vs_rise),
        .vs_fall  (vs_fall),
        .href_s2  (href_s2),
        .href_fall(href_fall),
        .dat_s2   (dat_s2)
    );

    state_t             state;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic               phase;
    logic [7:0]         hi;
    logic [ADDR_W-1:0]  addr;

    logic        byte_ok;
    logic        pix_done;
    logic        in_win;
    logic        last_wr;
    logic [15:0] pixel;
    int          row_i;
    int          col_i;

    always_comb begin
        row_i    = int'(row);
        col_i    = int'(col);
        byte_ok  = pclk_rise & href_s2;
        pix_done = byte_ok & phase;
        in_win   = (row_i >= Y_OFF) && (row_i < Y_OFF + ROWS) &&
                   (col_i >= X_OFF) && (col_i < X_OFF + COLS);
        last_wr  = pix_done & in_win & (addr == LAST_ADDR);
        pixel    = HI_BYTE_FIRST ? {hi, dat_s2} : {dat_s2, hi};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            col     <= '0;
            row     <= '0;
            phase   <= 1'b0;
            hi      <= '0;
            addr    <= '0;
        end else begin
            wr_en <= 1'b0;
            if (abort && state != IDLE) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            state <= ARM;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                            err   <= 1'b0;
                        end
                    end
                    ARM: begin
                        if (vs_rise) state <= SYNC;
                    end
                    SYNC: begin
                        if (vs_fall) begin
                            state <= CAPTURE;
                            row   <= '0;
                            col   <= '0;
                            phase <= 1'b0;
                            addr  <= '0;
                        end
                    end
                    CAPTURE: begin
                        if (href_fall) begin
                            row   <= (&row) ? row : row + ROW_W'(1);
                            col   <= '0;
                            phase <= 1'b0;
                        end else if (byte_ok) begin
                            phase <= ~phase;
                            if (!phase) hi <= dat_s2;
                        end
                        if (pix_done) begin
                            col <= (&col) ? col : col + COL_W'(1);
                            if (in_win) begin
                                wr_en   <= 1'b1;
                                wr_data <= pixel;
                                wr_addr <= addr;
                                addr    <= addr + ADDR_W'(1);
                            end
                        end
                        // a frame that ends before the window fills is an error
                        if (last_wr) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else if (vs_rise) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Bench: two controllers (window at 0,0 and at 1,1) share one modelled
// camera; expected writes are queued as bytes are driven.
module tb_cam_capture_ctrl;

    localparam int AW = 4;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [15:0]   d;
    } wr_t;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          cam_pclk = 1'b0;
    logic          cam_vsync = 1'b0;
    logic          cam_href = 1'b0;
    logic [7:0]    cam_dat = '0;
    logic          start0 = 1'b0, abort0 = 1'b0;
    logic          start1 = 1'b0, abort1 = 1'b0;
    logic          busy0, done0, err0, wr_en0;
    logic          busy1, done1, err1, wr_en1;
    logic [AW-1:0] wr_addr0, wr_addr1;
    logic [15:0]   wr_data0, wr_data1;

    cam_capture_ctrl #(
        .COLS(4), .ROWS(2), .X_OFF(0), .Y_OFF(0), .ADDR_W(AW)
    ) dut0 (
        .clk(clk), .resetn(resetn),
        .cam_pclk(cam_pclk), .cam_vsync(cam_vsync),
        .cam_href(cam_href), .cam_dat(cam_dat),
        .start(start0), .abort(abort0),
        .busy(busy0), .done(done0), .err(err0),
        .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0)
    );

    cam_capture_ctrl #(
        .COLS(4), .ROWS(2), .X_OFF(1), .Y_OFF(1), .ADDR_W(AW)
    ) dut1 (
        .clk(clk), .resetn(resetn),
        .cam_pclk(cam_pclk), .cam_vsync(cam_vsync),
        .cam_href(cam_href), .cam_dat(cam_dat),
        .start(start1), .abort(abort1),
        .busy(busy1), .done(done1), .err(err1),
        .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1)
    );

    always #5 clk = ~clk;
    always #40 cam_pclk = ~cam_pclk;

    int n_checks = 0;
    int n_errors = 0;

    wr_t q0[$];
    wr_t q1[$];
    wr_t e0, e1;
    bit  cap0, cap1;
    int  lim0 = 1000, lim1 = 1000;
    int  pushed0, pushed1, ad0, ad1;
    int  wc0, wc1;
    logic [15:0]   first0, first1;
    logic [AW-1:0] last0, last1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_px(input int l, input int p, input logic [15:0] d);
        if (cap0 && l < 2 && p < 4 && pushed0 < lim0) begin
            q0.push_back({AW'(ad0), d});
            ad0++;
            pushed0++;
        end
        if (cap1 && l >= 1 && l < 3 && p >= 1 && p < 5 && pushed1 < lim1) begin
            q1.push_back({AW'(ad1), d});
            ad1++;
            pushed1++;
        end
    endtask

    task automatic pclks(input int n);
        repeat (n) @(negedge cam_pclk);
    endtask

    // vsync pulse, blanking, nlines of 6 pixels (12 bytes), trailing gap
    task automatic send_frame(input int nlines, input bit c0, input bit c1);
        logic [7:0] b;
        cap0 = c0;
        cap1 = c1;
        pushed0 = 0;
        pushed1 = 0;
        ad0 = 0;
        ad1 = 0;
        @(negedge cam_pclk);
        cam_vsync = 1'b1;
        pclks(4);
        cam_vsync = 1'b0;
        pclks(4);
        for (int l = 0; l < nlines; l++) begin
            for (int j = 0; j < 12; j++) begin
                b = 8'(12 * l + j);
                cam_href = 1'b1;
                cam_dat = b;
                if (j % 2 == 1) model_px(l, j / 2, {b - 8'd1, b});
                @(negedge cam_pclk);
            end
            cam_href = 1'b0;
            pclks(4);
        end
        pclks(4);
    endtask

    task automatic pulse_start(input bit s0, input bit s1);
        @(negedge clk);
        start0 = s0;
        start1 = s1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    always @(negedge clk) begin
        if (wr_en0) begin
            check("wr0_expected", 32'(q0.size() != 0), 1);
            if (q0.size() != 0) begin
                e0 = q0.pop_front();
                check("wr0_addr", 32'(wr_addr0), 32'(e0.a));
                check("wr0_data", 32'(wr_data0), 32'(e0.d));
            end
            if (wc0 == 0) first0 = wr_data0;
            last0 = wr_addr0;
            wc0++;
        end
        if (wr_en1) begin
            check("wr1_expected", 32'(q1.size() != 0), 1);
            if (q1.size() != 0) begin
                e1 = q1.pop_front();
                check("wr1_addr", 32'(wr_addr1), 32'(e1.a));
                check("wr1_data", 32'(wr_data1), 32'(e1.d));
            end
            if (wc1 == 0) first1 = wr_data1;
            last1 = wr_addr1;
            wc1++;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy0", 32'(busy0), 0);
        check("rst_done0", 32'(done0), 0);
        check("rst_err0", 32'(err0), 0);
        check("rst_wr_en0", 32'(wr_en0), 0);
        resetn = 1'b1;

        // idle with camera running
        wc0 = 0;
        wc1 = 0;
        send_frame(3, 1'b0, 1'b0);
        check("idle_wc0", wc0, 0);
        check("idle_wc1", wc1, 0);
        check("idle_busy0", 32'(busy0), 0);
        check("idle_done0", 32'(done0), 0);
        check("idle_err1", 32'(err1), 0);

        // start and abort together in IDLE: abort wins
        @(negedge clk);
        start0 = 1'b1;
        abort0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        abort0 = 1'b0;
        check("sa_busy0", 32'(busy0), 0);

        // full capture on both windows
        pulse_start(1'b1, 1'b1);
        check("t1_busy0", 32'(busy0), 1);
        check("t1_busy1", 32'(busy1), 1);
        wc0 = 0;
        wc1 = 0;
        send_frame(3, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        check("t1_wc0", wc0, 8);
        check("t1_first0", 32'(first0), 32'h0001);
        check("t1_last0", 32'(last0), 7);
        check("t1_done0", 32'(done0), 1);
        check("t1_err0", 32'(err0), 0);
        check("t1_busy0_end", 32'(busy0), 0);
        check("t1_wc1", wc1, 8);
        check("t1_first1", 32'(first1), 32'h0E0F);
        check("t1_last1", 32'(last1), 7);
        check("t1_done1", 32'(done1), 1);
        check("t1_err1", 32'(err1), 0);
        check("t1_q0", q0.size(), 0);
        check("t1_q1", q1.size(), 0);

        // frame ends after one line
        pulse_start(1'b1, 1'b1);
        check("t2_done0_clr", 32'(done0), 0);
        wc0 = 0;
        wc1 = 0;
        send_frame(1, 1'b1, 1'b1);
        send_frame(0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check("t2_wc0", wc0, 4);
        check("t2_last0", 32'(last0), 3);
        check("t2_done0", 32'(done0), 1);
        check("t2_err0", 32'(err0), 1);
        check("t2_wc1", wc1, 0);
        check("t2_done1", 32'(done1), 1);
        check("t2_err1", 32'(err1), 1);

        // abort after three writes
        pulse_start(1'b1, 1'b0);
        check("t3_err0_clr", 32'(err0), 0);
        wc0 = 0;
        lim0 = 3;
        fork
            send_frame(3, 1'b1, 1'b0);
            begin
                int t = 0;
                while (wc0 < 3 && t < 5000) begin
                    @(negedge clk);
                    t++;
                end
                check("t3_wait", 32'(wc0 >= 3), 1);
                abort0 = 1'b1;
                @(negedge clk);
                abort0 = 1'b0;
                check("t3_busy0", 32'(busy0), 0);
                check("t3_done0", 32'(done0), 0);
            end
        join
        repeat (4) @(negedge clk);
        check("t3_wc0", wc0, 3);
        check("t3_done0_end", 32'(done0), 0);
        check("t3_q0", q0.size(), 0);
        lim0 = 1000;

        // start in the middle of a frame waits for the next one
        wc0 = 0;
        fork
            send_frame(3, 1'b0, 1'b0);
            begin
                repeat (200) @(negedge clk);
                pulse_start(1'b1, 1'b0);
            end
        join
        check("t4_wc0_wait", wc0, 0);
        check("t4_busy0", 32'(busy0), 1);
        send_frame(3, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        check("t4_wc0", wc0, 8);
        check("t4_first0", 32'(first0), 32'h0001);
        check("t4_done0", 32'(done0), 1);
        check("t4_err0", 32'(err0), 0);

        // reset in the middle of a capture
        pulse_start(1'b1, 1'b0);
        wc0 = 0;
        lim0 = 2;
        fork
            send_frame(3, 1'b1, 1'b0);
            begin
                int t = 0;
                while (wc0 < 2 && t < 5000) begin
                    @(negedge clk);
                    t++;
                end
                check("t5_wait", 32'(wc0 >= 2), 1);
                resetn = 1'b0;
                #1;
                check("t5_busy0", 32'(busy0), 0);
                check("t5_wr_en0", 32'(wr_en0), 0);
                check("t5_done0", 32'(done0), 0);
                @(negedge clk);
                resetn = 1'b1;
            end
        join
        repeat (4) @(negedge clk);
        check("t5_wc0", wc0, 2);
        check("t5_busy0_end", 32'(busy0), 0);
        check("t5_q0", q0.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
